// File: rtl/reg_access_arbiter_if.sv
// Requester and register-port bundle for reg_access_arbiter.
// The arbiter uses the slave view; the requesters/register model use the master view.
interface reg_access_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [1:0]          req_verify;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic [1:0]          reg_enable;
    logic [ADDR_W-1:0]   reg_addr;
    logic [DATA_W-1:0]   reg_datain;
    logic [DATA_W-1:0]   reg_dataout;

    modport slave (
        input  req_valid, req_write, req_verify, req_addr, req_data, reg_dataout,
        output req_ready, rsp_valid, rsp_data, rsp_err, reg_enable, reg_addr, reg_datain
    );

    modport master (
        output req_valid, req_write, req_verify, req_addr, req_data, reg_dataout,
        input  req_ready, rsp_valid, rsp_data, rsp_err, reg_enable, reg_addr, reg_datain
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Shares one inband register port between two requesters with round-robin
// arbitration; runs read, write or write-with-readback-verify one at a time.
module reg_access_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    reg_access_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_GAP  = 3'd3,
        ST_VRD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                port_q, port_d;
    logic                write_q, write_d;
    logic                verify_q, verify_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          reg_enable_q, reg_enable_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_datain_q, reg_datain_d;
    logic                sel_s;
    logic                hs_s;

    function automatic logic [1:0] port_mask(input logic port);
        port_mask = port ? 2'b10 : 2'b01;
    endfunction

    // Round-robin selection: on contention the port not granted last wins
    always_comb begin
        sel_s = 1'b0;
        if (&bus.req_valid) begin
            sel_s = ~last_grant_q;
        end else if (bus.req_valid[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        hs_s = (state_q == ST_IDLE) && (|bus.req_valid) && !reset;
    end

    assign bus.req_ready = hs_s ? port_mask(sel_s) : 2'b00;

    // Sequencer next state, request latching and response capture
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        write_d      = write_q;
        verify_d     = verify_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    last_grant_d = sel_s;
                    port_d       = sel_s;
                    write_d      = bus.req_write[sel_s];
                    verify_d     = bus.req_verify[sel_s];
                    addr_d       = sel_s ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
                    data_d       = sel_s ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
                    state_d      = bus.req_write[sel_s] ? ST_WR : ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                rsp_data_d = bus.reg_dataout;
                rsp_err_d  = 1'b0;
                state_d    = ST_DONE;
            end
            ST_WR: begin
                if (verify_q) begin
                    state_d = ST_GAP;
                end else begin
                    rsp_data_d = {DATA_W{1'b0}};
                    rsp_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_GAP: begin
                state_d = ST_VRD;
            end
            ST_VRD: begin
                rsp_data_d = bus.reg_dataout;
                rsp_err_d  = (bus.reg_dataout != data_q);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-port and response-pulse outputs, decoded from the upcoming state
    always_comb begin
        reg_enable_d = 2'b00;
        reg_addr_d   = {ADDR_W{1'b0}};
        reg_datain_d = {DATA_W{1'b0}};
        rsp_valid_d  = 2'b00;
        case (state_d)
            ST_RD, ST_VRD: begin
                reg_enable_d = 2'b11;
                reg_addr_d   = addr_d;
            end
            ST_WR: begin
                reg_enable_d = 2'b10;
                reg_addr_d   = addr_d;
                reg_datain_d = data_d;
            end
            ST_DONE: begin
                rsp_valid_d = port_mask(port_d);
            end
            default: begin
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            verify_q     <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            rsp_data_q   <= {DATA_W{1'b0}};
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
            reg_enable_q <= 2'b00;
            reg_addr_q   <= {ADDR_W{1'b0}};
            reg_datain_q <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            write_q      <= write_d;
            verify_q     <= verify_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            reg_enable_q <= reg_enable_d;
            reg_addr_q   <= reg_addr_d;
            reg_datain_q <= reg_datain_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.reg_enable = reg_enable_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_datain = reg_datain_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed plus randomized bench for reg_access_arbiter against a shadow
// register map and a cycle-by-cycle transaction timeline.
module tb_reg_access_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic dev_load;
    logic broken;

    always #5 clk = ~clk;

    reg_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    reg_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register device: stores strobed writes; "broken" makes it read-only returning all ones
    logic [DW-1:0] dev_mem [128];
    logic [DW-1:0] ref_mem [128];

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        if (i == 9) v = 32'h0000_1234;
        return v;
    endfunction

    assign bus.reg_dataout = broken ? 32'hFFFF_FFFF : dev_mem[bus.reg_addr];

    always @(posedge clk) begin
        if (dev_load) begin
            for (int i = 0; i < 128; i++) dev_mem[i] <= init_val(i);
        end else if (bus.reg_enable === 2'b10 && !broken) begin
            dev_mem[bus.reg_addr] <= bus.reg_datain;
        end
    end

    // Activity counters for whole-run totals
    int strobe_cnt = 0;
    int rsp_cnt0 = 0;
    int rsp_cnt1 = 0;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.reg_enable[1] === 1'b1) strobe_cnt <= strobe_cnt + 1;
            if (bus.rsp_valid[0] === 1'b1) rsp_cnt0 <= rsp_cnt0 + 1;
            if (bus.rsp_valid[1] === 1'b1) rsp_cnt1 <= rsp_cnt1 + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_strobe = 0;
    int exp_rsp0 = 0;
    int exp_rsp1 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] mask(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic set_req(input int p, input bit w, input bit v,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[p]          = w;
        bus.req_verify[p]         = v;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_data[p*DW +: DW]  = d;
    endtask

    task automatic wait_ready(input logic [1:0] want, inout int cyc);
        int n;
        n = 0;
        #1;
        while (bus.req_ready === 2'b00 && n < 20) begin
            @(negedge clk); #1;
            n++;
            cyc++;
        end
        chk("grant", bus.req_ready, want);
    endtask

    // One complete transaction from request to idle, checking each cycle
    task automatic txn(input int p, input bit w, input bit v,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
        logic [DW-1:0] exp_data;
        bit exp_err;
        int cyc;
        cyc = 0;
        if (!w) begin
            exp_data = broken ? 32'hFFFF_FFFF : ref_mem[a];
            exp_err  = 1'b0;
        end else if (!v) begin
            exp_data = 32'h0;
            exp_err  = 1'b0;
        end else begin
            exp_data = broken ? 32'hFFFF_FFFF : d;
            exp_err  = (exp_data != d);
        end
        set_req(p, w, v, a, d);
        bus.req_valid[p] = 1'b1;
        wait_ready(mask(p), cyc);
        @(negedge clk);
        bus.req_valid[p] = 1'b0;
        if (poke) begin
            set_req(1, 1'b0, 1'b0, 7'd5, 32'h0);
            bus.req_valid[1] = 1'b1;
        end
        #1;
        chk("c1_enable", bus.reg_enable, w ? 2'b10 : 2'b11);
        chk("c1_addr", bus.reg_addr, a);
        chk("c1_datain", bus.reg_datain, w ? d : 32'h0);
        chk("c1_rsp_valid", bus.rsp_valid, 2'b00);
        chk("c1_ready", bus.req_ready, 2'b00);
        if (w && v) begin
            @(negedge clk); #1;
            chk("gap_enable", bus.reg_enable, 2'b00);
            chk("gap_addr", bus.reg_addr, 7'd0);
            @(negedge clk); #1;
            chk("vrd_enable", bus.reg_enable, 2'b11);
            chk("vrd_addr", bus.reg_addr, a);
        end
        @(negedge clk);
        if (poke) bus.req_valid[1] = 1'b0;
        #1;
        chk("done_rsp_valid", bus.rsp_valid, mask(p));
        chk("done_rsp_data", bus.rsp_data, exp_data);
        chk("done_rsp_err", bus.rsp_err, exp_err);
        chk("done_enable", bus.reg_enable, 2'b00);
        @(negedge clk); #1;
        chk("idle_rsp_valid", bus.rsp_valid, 2'b00);
        chk("idle_ready", bus.req_ready, 2'b00);
        if (w && !broken) ref_mem[a] = d;
        exp_strobe += (w && v) ? 2 : 1;
        if (p == 1) exp_rsp1++; else exp_rsp0++;
    endtask

    // Both ports hold reads; grants must alternate starting at port 0, every 3 cycles
    task automatic contention(input int n);
        int cyc;
        int prev;
        int ep;
        logic [AW-1:0] ea;
        cyc = 0;
        prev = 0;
        ep = 0;
        set_req(0, 1'b0, 1'b0, 7'd9, 32'h0);
        set_req(1, 1'b0, 1'b0, 7'd20, 32'h0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < n; k++) begin
            wait_ready(mask(ep), cyc);
            if (k > 0) chk("cont_spacing", 64'(cyc - prev), 64'd3);
            prev = cyc;
            ea = (ep == 1) ? 7'd20 : 7'd9;
            @(negedge clk); #1; cyc++;
            chk("cont_rd_enable", bus.reg_enable, 2'b11);
            chk("cont_rd_addr", bus.reg_addr, ea);
            @(negedge clk); cyc++;
            if (k == n - 1) bus.req_valid = 2'b00;
            #1;
            chk("cont_rsp_valid", bus.rsp_valid, mask(ep));
            chk("cont_rsp_data", bus.rsp_data, ref_mem[ea]);
            exp_strobe++;
            if (ep == 1) exp_rsp1++; else exp_rsp0++;
            ep = 1 - ep;
        end
        @(negedge clk); #1;
        chk("cont_idle_ready", bus.req_ready, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int rp;
    bit rw, rv;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int dummy;

    initial begin
        reset = 1'b1;
        dev_load = 1'b1;
        broken = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        bus.req_verify = 2'b00;
        bus.req_addr = '0;
        bus.req_data = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        dev_load = 1'b0;
        #1;
        chk("rst_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_enable", bus.reg_enable, 2'b00);
        chk("rst_addr", bus.reg_addr, 7'd0);
        chk("rst_datain", bus.reg_datain, 32'h0);

        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 7'd9, 32'h0);
        set_req(1, 1'b0, 1'b0, 7'd20, 32'h0);
        reset = 1'b0;
        contention(4);

        txn(0, 1'b0, 1'b0, 7'd9, 32'h0, 1'b0);
        txn(1, 1'b1, 1'b0, 7'd51, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b1, 1'b1, 7'd51, 32'h0000_0055, 1'b0);
        broken = 1'b1;
        txn(1, 1'b1, 1'b1, 7'd51, 32'h0000_0055, 1'b0);
        broken = 1'b0;
        txn(0, 1'b0, 1'b0, 7'd20, 32'h0, 1'b1);
        txn(0, 1'b0, 1'b0, 7'd127, 32'h0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            rp = int'($urandom_range(1, 0));
            rw = 1'($urandom_range(1, 0));
            rv = 1'($urandom_range(1, 0));
            ra = 7'($urandom_range(127, 0));
            rd = $urandom;
            txn(rp, rw, rv, ra, rd, 1'b0);
        end

        // Reset during GAP of a port-0 verify: no response, port 0 still wins next contention
        dummy = 0;
        set_req(0, 1'b1, 1'b1, 7'd51, 32'hA5A5_0001);
        bus.req_valid[0] = 1'b1;
        wait_ready(2'b01, dummy);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        chk("abort_wr_enable", bus.reg_enable, 2'b10);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_gap_enable", bus.reg_enable, 2'b00);
        @(negedge clk); #1;
        chk("abort_rsp_valid", bus.rsp_valid, 2'b00);
        chk("abort_enable", bus.reg_enable, 2'b00);
        chk("abort_rsp_data", bus.rsp_data, 32'h0);
        chk("abort_ready", bus.req_ready, 2'b00);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("abort_no_rsp", bus.rsp_valid, 2'b00);
        chk("abort_idle_enable", bus.reg_enable, 2'b00);
        ref_mem[51] = 32'hA5A5_0001;
        exp_strobe++;
        contention(2);

        repeat (2) @(negedge clk);
        #1;
        chk("total_strobes", 64'(strobe_cnt), 64'(exp_strobe));
        chk("total_rsp0", 64'(rsp_cnt0), 64'(exp_rsp0));
        chk("total_rsp1", 64'(rsp_cnt1), 64'(exp_rsp1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
